// File: rtl/divider_pkg.sv
// Shared types and helpers for the pipelined restoring divider.
// Latency helper and the post-stage fix-up kind live here.
package divider_pkg;

  typedef enum logic [1:0] {
    FIX_NONE,
    FIX_DIV0,
    FIX_OVF
  } fix_t;

  function automatic int div_latency(
    input int width,
    input int bps
  );
    return width / bps + 2;
  endfunction

endpackage

// File: rtl/div_stage.sv
// One iterative stage: BITS_PER_STAGE restoring steps, then a register.
// DIVIDER_TAG_EN adds a sideband tag register that moves with the data.
module div_stage
  import divider_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_STAGE = 1
`ifdef DIVIDER_TAG_EN
  ,
  parameter int TAG_WIDTH      = 8
`endif
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             advance,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_rem,
  input  logic [WIDTH-1:0] up_dq,
  input  logic [WIDTH-1:0] up_dvs,
  input  fix_t             up_fix,
  input  logic             up_qneg,
  input  logic             up_rneg,
  output logic             valid,
  output logic [WIDTH-1:0] rem,
  output logic [WIDTH-1:0] dq,
  output logic [WIDTH-1:0] dvs,
  output fix_t             fix,
  output logic             qneg,
  output logic             rneg
`ifdef DIVIDER_TAG_EN
  ,
  input  logic [TAG_WIDTH-1:0] up_tag,
  output logic [TAG_WIDTH-1:0] tag
`endif
);

  // dq starts as the dividend magnitude and fills with quotient bits
  // from the right as dividend bits leave on the left.
  logic [WIDTH:0]   cur_rem;
  logic [WIDTH-1:0] cur_dq;

  // restoring steps for this stage
  always_comb begin
    cur_rem = {1'b0, up_rem};
    cur_dq  = up_dq;
    for (int b = 0; b < BITS_PER_STAGE; b++) begin
      cur_rem = {cur_rem[WIDTH-1:0], cur_dq[WIDTH-1]};
      cur_dq  = {cur_dq[WIDTH-2:0], 1'b0};
      if (cur_rem >= {1'b0, up_dvs}) begin
        cur_rem   = cur_rem - {1'b0, up_dvs};
        cur_dq[0] = 1'b1;
      end
    end
  end

  // stage register, shifts only on advance
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      valid <= 1'b0;
      rem   <= '0;
      dq    <= '0;
      dvs   <= '0;
      fix   <= FIX_NONE;
      qneg  <= 1'b0;
      rneg  <= 1'b0;
    end else if (advance) begin
      valid <= up_valid;
      rem   <= cur_rem[WIDTH-1:0];
      dq    <= cur_dq;
      dvs   <= up_dvs;
      fix   <= up_fix;
      qneg  <= up_qneg;
      rneg  <= up_rneg;
    end
  end

`ifdef DIVIDER_TAG_EN
  // sideband tag follows the same stall rule
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      tag <= '0;
    end else if (advance) begin
      tag <= up_tag;
    end
  end
`endif

endmodule

// File: rtl/pipelined_divider.sv
// Fully pipelined restoring divider, signed/unsigned per operation.
// Define DIVIDER_TAG_EN to add tag_in/tag_out carried with each result.
module pipelined_divider
  import divider_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_STAGE = 1,
  parameter int TAG_WIDTH      = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] dividend_in,
  input  logic [WIDTH-1:0] divisor_in,
  input  logic             signed_in,
  input  logic             data_valid_in,
  output logic             data_ready_out,
  output logic [WIDTH-1:0] quotient_out,
  output logic [WIDTH-1:0] remainder_out,
  output logic             data_valid_out,
  input  logic             data_ready_in,
  output logic             error_out,
  output logic             busy_out
`ifdef DIVIDER_TAG_EN
  ,
  input  logic [TAG_WIDTH-1:0] tag_in,
  output logic [TAG_WIDTH-1:0] tag_out
`endif
);

  localparam int S = div_latency(WIDTH, BITS_PER_STAGE) - 2;
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  if (WIDTH < 2) begin : g_bad_width
    $error("pipelined_divider: WIDTH must be >= 2");
  end
  if (WIDTH % BITS_PER_STAGE != 0) begin : g_bad_bps
    $error("pipelined_divider: WIDTH not a multiple of BITS_PER_STAGE");
  end
  if (TAG_WIDTH < 1) begin : g_bad_tag
    $error("pipelined_divider: TAG_WIDTH must be >= 1");
  end

  function automatic logic [WIDTH-1:0] abs_val(
    input logic [WIDTH-1:0] x,
    input logic             neg
  );
    return neg ? -x : x;
  endfunction

  logic             advance;
  logic             dvd_neg;
  logic             dvs_neg;
  fix_t             in_fix;

  logic             pre_valid;
  logic [WIDTH-1:0] pre_dvd;
  logic [WIDTH-1:0] pre_dvs;
  fix_t             pre_fix;
  logic             pre_qneg;
  logic             pre_rneg;

  logic             st_valid [S+1];
  logic [WIDTH-1:0] st_rem   [S+1];
  logic [WIDTH-1:0] st_dq    [S+1];
  logic [WIDTH-1:0] st_dvs   [S+1];
  fix_t             st_fix   [S+1];
  logic             st_qneg  [S+1];
  logic             st_rneg  [S+1];

  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  assign advance        = !data_valid_out || data_ready_in;
  assign data_ready_out = advance;

  // operand signs and special-case classification at the input
  always_comb begin
    dvd_neg = signed_in & dividend_in[WIDTH-1];
    dvs_neg = signed_in & divisor_in[WIDTH-1];
    in_fix  = FIX_NONE;
    unique case (1'b1)
      divisor_in == '0: in_fix = FIX_DIV0;
      signed_in && dividend_in == MIN_VAL
        && divisor_in == '1: in_fix = FIX_OVF;
      default: ;
    endcase
  end

  // pre-stage: magnitudes, signs and fix-up kind
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pre_valid <= 1'b0;
      pre_dvd   <= '0;
      pre_dvs   <= '0;
      pre_fix   <= FIX_NONE;
      pre_qneg  <= 1'b0;
      pre_rneg  <= 1'b0;
    end else if (advance) begin
      pre_valid <= data_valid_in;
      pre_dvd   <= abs_val(dividend_in, dvd_neg);
      pre_dvs   <= abs_val(divisor_in, dvs_neg);
      pre_fix   <= in_fix;
      pre_qneg  <= dvd_neg ^ dvs_neg;
      pre_rneg  <= dvd_neg;
    end
  end

  assign st_valid[0] = pre_valid;
  assign st_rem[0]   = '0;
  assign st_dq[0]    = pre_dvd;
  assign st_dvs[0]   = pre_dvs;
  assign st_fix[0]   = pre_fix;
  assign st_qneg[0]  = pre_qneg;
  assign st_rneg[0]  = pre_rneg;

`ifdef DIVIDER_TAG_EN
  logic [TAG_WIDTH-1:0] pre_tag;
  logic [TAG_WIDTH-1:0] st_tag [S+1];

  // pre-stage tag register
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pre_tag <= '0;
    end else if (advance) begin
      pre_tag <= tag_in;
    end
  end

  assign st_tag[0] = pre_tag;
`endif

  for (genvar i = 0; i < S; i++) begin : g_stage
    div_stage #(
      .WIDTH          (WIDTH),
      .BITS_PER_STAGE (BITS_PER_STAGE)
`ifdef DIVIDER_TAG_EN
      ,
      .TAG_WIDTH      (TAG_WIDTH)
`endif
    ) u_stage (
      .clk_in   (clk_in),
      .rst_in   (rst_in),
      .advance  (advance),
      .up_valid (st_valid[i]),
      .up_rem   (st_rem[i]),
      .up_dq    (st_dq[i]),
      .up_dvs   (st_dvs[i]),
      .up_fix   (st_fix[i]),
      .up_qneg  (st_qneg[i]),
      .up_rneg  (st_rneg[i]),
      .valid    (st_valid[i+1]),
      .rem      (st_rem[i+1]),
      .dq       (st_dq[i+1]),
      .dvs      (st_dvs[i+1]),
      .fix      (st_fix[i+1]),
      .qneg     (st_qneg[i+1]),
      .rneg     (st_rneg[i+1])
`ifdef DIVIDER_TAG_EN
      ,
      .up_tag   (st_tag[i]),
      .tag      (st_tag[i+1])
`endif
    );
  end

  // sign restore and special cases; with a zero divisor the remainder
  // magnitude equals |dividend|, so re-signing it yields the dividend
  always_comb begin
    q_fix = st_qneg[S] ? -st_dq[S] : st_dq[S];
    r_fix = st_rneg[S] ? -st_rem[S] : st_rem[S];
    unique case (1'b1)
      st_fix[S] == FIX_DIV0: q_fix = '1;
      st_fix[S] == FIX_OVF: begin
        q_fix = MIN_VAL;
        r_fix = '0;
      end
      default: ;
    endcase
  end

  // post-stage output register
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      data_valid_out <= 1'b0;
      quotient_out   <= '0;
      remainder_out  <= '0;
      error_out      <= 1'b0;
    end else if (advance) begin
      data_valid_out <= st_valid[S];
      quotient_out   <= q_fix;
      remainder_out  <= r_fix;
      error_out      <= st_fix[S] == FIX_DIV0;
    end
  end

`ifdef DIVIDER_TAG_EN
  // tag output register
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      tag_out <= '0;
    end else if (advance) begin
      tag_out <= st_tag[S];
    end
  end
`endif

  // any valid operation anywhere in the pipe
  always_comb begin
    busy_out = data_valid_out;
    for (int i = 0; i <= S; i++) begin
      busy_out = busy_out | st_valid[i];
    end
  end

endmodule

// File: tb/tb_pipelined_divider.sv
// Bench for pipelined_divider: 32/1 and 16/4 instances, scoreboarded.
// Tags are checked when DIVIDER_TAG_EN is defined.
module tb_pipelined_divider;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        e;
    logic [7:0]  t;
  } exp_t;

  logic clk;
  logic rst;

  logic [31:0] a_dvd, a_dvs, a_q, a_r;
  logic        a_sgn, a_vin, a_rout, a_vout, a_rdy, a_err, a_busy;
  logic [7:0]  a_tag;

  logic [15:0] b_dvd, b_dvs, b_q, b_r;
  logic        b_sgn, b_vin, b_rout, b_vout, b_rdy, b_err, b_busy;
  logic [7:0]  b_tag;

`ifdef DIVIDER_TAG_EN
  logic [7:0]  a_tout, b_tout;
`endif

  exp_t qa[$];
  exp_t qb[$];
  exp_t exp_a, exp_b;

  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;
  int n_acc_a = 0;
  int n_acc_b = 0;

  pipelined_divider #(
    .WIDTH(32), .BITS_PER_STAGE(1), .TAG_WIDTH(8)
  ) u_dut_a (
    .clk_in(clk), .rst_in(rst),
    .dividend_in(a_dvd), .divisor_in(a_dvs),
    .signed_in(a_sgn), .data_valid_in(a_vin),
    .data_ready_out(a_rout), .quotient_out(a_q),
    .remainder_out(a_r), .data_valid_out(a_vout),
    .data_ready_in(a_rdy), .error_out(a_err),
    .busy_out(a_busy)
`ifdef DIVIDER_TAG_EN
    , .tag_in(a_tag), .tag_out(a_tout)
`endif
  );

  pipelined_divider #(
    .WIDTH(16), .BITS_PER_STAGE(4), .TAG_WIDTH(8)
  ) u_dut_b (
    .clk_in(clk), .rst_in(rst),
    .dividend_in(b_dvd), .divisor_in(b_dvs),
    .signed_in(b_sgn), .data_valid_in(b_vin),
    .data_ready_out(b_rout), .quotient_out(b_q),
    .remainder_out(b_r), .data_valid_out(b_vout),
    .data_ready_in(b_rdy), .error_out(b_err),
    .busy_out(b_busy)
`ifdef DIVIDER_TAG_EN
    , .tag_in(b_tag), .tag_out(b_tout)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] obs,
                     input logic [63:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", name, obs, expv);
    end
  endtask

  function automatic exp_t model(input int w, input logic [31:0] a,
                                 input logic [31:0] b, input bit sg);
    exp_t x;
    longint sa, sb;
    logic [63:0] m;
    m = (64'd1 << w) - 64'd1;
    x.t = '0;
    x.e = (b == 0);
    if (b == 0) begin
      x.q = 32'(m);
      x.r = a;
    end else if (!sg) begin
      x.q = a / b;
      x.r = a % b;
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
      if (a[w-1]) sa = sa - longint'(64'd1 << w);
      if (b[w-1]) sb = sb - longint'(64'd1 << w);
      x.q = 32'(64'(sa / sb) & m);
      x.r = 32'(64'(sa % sb) & m);
    end
    return x;
  endfunction

  // one clock: handshake bookkeeping at negedge, hold check after posedge
  task automatic tick();
    bit acc_a, fire_a, hold_a, acc_b, fire_b, hold_b;
    logic [63:0] sv_a, sv_b;
    exp_t e;
    @(negedge clk);
    acc_a  = a_vin && a_rout;
    fire_a = a_vout && a_rdy;
    hold_a = a_vout && !a_rdy;
    acc_b  = b_vin && b_rout;
    fire_b = b_vout && b_rdy;
    hold_b = b_vout && !b_rdy;
    chk("A ready", a_rout, !a_vout || a_rdy);
    chk("B ready", b_rout, !b_vout || b_rdy);
    if (fire_a) begin
      chk("A expected", qa.size() != 0, 1);
      if (qa.size() != 0) begin
        e = qa.pop_front();
        chk("A quot", a_q, e.q);
        chk("A rem", a_r, e.r);
        chk("A err", a_err, e.e);
`ifdef DIVIDER_TAG_EN
        chk("A tag", a_tout, e.t);
`endif
      end
    end
    if (fire_b) begin
      chk("B expected", qb.size() != 0, 1);
      if (qb.size() != 0) begin
        e = qb.pop_front();
        chk("B quot", b_q, e.q);
        chk("B rem", b_r, e.r);
        chk("B err", b_err, e.e);
`ifdef DIVIDER_TAG_EN
        chk("B tag", b_tout, e.t);
`endif
      end
    end
    if (acc_a) begin
      e = exp_a;
      e.t = a_tag;
      qa.push_back(e);
      n_acc_a++;
    end
    if (acc_b) begin
      e = exp_b;
      e.t = b_tag;
      qb.push_back(e);
      n_acc_b++;
    end
    sv_a = {a_q, a_r};
    sv_b = {32'(b_q), 32'(b_r)};
    @(posedge clk);
    #1;
    if (hold_a) begin
      chk("A hold data", {a_q, a_r}, sv_a);
      chk("A hold valid", a_vout, 1);
    end
    if (hold_b) begin
      chk("B hold data", {32'(b_q), 32'(b_r)}, sv_b);
      chk("B hold valid", b_vout, 1);
    end
    if (acc_a) a_tag++;
    if (acc_b) b_tag++;
  endtask

  task automatic op_a(input logic [31:0] a, input logic [31:0] b,
                      input bit s, input logic [31:0] q,
                      input logic [31:0] r, input bit e);
    int g;
    a_dvd = a;
    a_dvs = b;
    a_sgn = s;
    a_vin = 1'b1;
    a_rdy = 1'b1;
    exp_a.q = q;
    exp_a.r = r;
    exp_a.e = e;
    tick();
    a_vin = 1'b0;
    g = 0;
    while (qa.size() != 0 && g < 100) begin
      tick();
      g++;
    end
    chk("A op drained", qa.size(), 0);
  endtask

  task automatic op_b(input logic [15:0] a, input logic [15:0] b,
                      input bit s, input logic [15:0] q,
                      input logic [15:0] r, input bit e);
    int g;
    b_dvd = a;
    b_dvs = b;
    b_sgn = s;
    b_vin = 1'b1;
    b_rdy = 1'b1;
    exp_b.q = 32'(q);
    exp_b.r = 32'(r);
    exp_b.e = e;
    tick();
    b_vin = 1'b0;
    g = 0;
    while (qb.size() != 0 && g < 100) begin
      tick();
      g++;
    end
    chk("B op drained", qb.size(), 0);
  endtask

  task automatic rand_a();
    int pick;
    pick  = $urandom_range(0, 9);
    a_dvd = $urandom;
    a_dvs = $urandom;
    a_sgn = 1'($urandom_range(0, 1));
    if (pick == 0) a_dvs = 32'd0;
    if (pick == 1) begin
      a_dvd = 32'h8000_0000;
      a_dvs = 32'hFFFF_FFFF;
    end
    if (pick == 2 || pick == 3) a_dvs = 32'($urandom_range(1, 15));
    exp_a = model(32, a_dvd, a_dvs, a_sgn);
  endtask

  task automatic rand_b();
    int pick;
    pick  = $urandom_range(0, 9);
    b_dvd = 16'($urandom);
    b_dvs = 16'($urandom);
    b_sgn = 1'($urandom_range(0, 1));
    if (pick == 0) b_dvs = 16'd0;
    if (pick == 1) begin
      b_dvd = 16'h8000;
      b_dvs = 16'hFFFF;
    end
    if (pick == 2 || pick == 3) b_dvs = 16'($urandom_range(1, 9));
    exp_b = model(16, {16'd0, b_dvd}, {16'd0, b_dvs}, b_sgn);
  endtask

  initial begin
    int cnt, g, n0;
    rst   = 1'b1;
    a_dvd = '0; a_dvs = '0; a_sgn = 1'b0; a_vin = 1'b0;
    a_rdy = 1'b1; a_tag = '0;
    b_dvd = '0; b_dvs = '0; b_sgn = 1'b0; b_vin = 1'b0;
    b_rdy = 1'b1; b_tag = '0;
    exp_a = '{q: '0, r: '0, e: 1'b0, t: '0};
    exp_b = exp_a;

    // reset state
    #12;
    chk("reset A quot", a_q, 0);
    chk("reset A rem", a_r, 0);
    chk("reset A valid", a_vout, 0);
    chk("reset A err", a_err, 0);
    chk("reset A busy", a_busy, 0);
    chk("reset B valid", b_vout, 0);
    chk("reset B busy", b_busy, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("reset A ready", a_rout, 1);

    // 100/7 with latency measurement
    a_dvd = 32'd100; a_dvs = 32'd7; a_sgn = 1'b0; a_vin = 1'b1;
    exp_a.q = 32'd14; exp_a.r = 32'd2; exp_a.e = 1'b0;
    tick();
    a_vin = 1'b0;
    chk("A busy in flight", a_busy, 1);
    cnt = 1;
    while (!a_vout && cnt < 100) begin
      tick();
      cnt++;
    end
    chk("A latency", cnt, 34);
    tick();
    chk("A queue after 100/7", qa.size(), 0);
    chk("A idle", a_busy, 0);

    // signed, overflow and divide-by-zero corners
    op_a(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    op_a(32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0);
    op_a(32'h8000_0000, 32'hFFFF_FFFF, 1'b1,
         32'h8000_0000, 32'd0, 1'b0);
    op_a(32'd55, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd55, 1'b1);
    op_a(32'hFFFF_FFFB, 32'd0, 1'b1,
         32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1);
    op_a(32'hFFFF_FFF9, 32'd2, 1'b0, 32'h7FFF_FFFC, 32'd1, 1'b0);

    // random stream with random backpressure
    n0 = n_acc_a;
    g = 0;
    while (n_acc_a - n0 < 40 && g < 2000) begin
      rand_a();
      a_vin = ($urandom_range(0, 3) != 0);
      a_rdy = 1'($urandom_range(0, 1));
      tick();
      g++;
    end
    a_vin = 1'b0;
    chk("A stream accepted", n_acc_a - n0, 40);
    g = 0;
    while (qa.size() != 0 && g < 2000) begin
      a_rdy = 1'($urandom_range(0, 1));
      tick();
      g++;
    end
    chk("A stream drained", qa.size(), 0);
    a_rdy = 1'b1;
    tick();
    chk("A stream idle", a_busy, 0);

    // asynchronous reset with ten operations in flight
    for (int i = 0; i < 10; i++) begin
      rand_a();
      a_vin = 1'b1;
      tick();
    end
    a_vin = 1'b0;
    tick();
    chk("A busy before reset", a_busy, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid reset A quot", a_q, 0);
    chk("mid reset A rem", a_r, 0);
    chk("mid reset A valid", a_vout, 0);
    chk("mid reset A err", a_err, 0);
    chk("mid reset A busy", a_busy, 0);
    chk("mid reset B busy", b_busy, 0);
    qa.delete();
    qb.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post reset A ready", a_rout, 1);
    repeat (50) tick();
    chk("post reset A busy", a_busy, 0);

    // 16-bit, 4 bits per stage: latency then directed ops
    b_dvd = 16'd1000; b_dvs = 16'd7; b_sgn = 1'b0; b_vin = 1'b1;
    exp_b.q = 32'd142; exp_b.r = 32'd6; exp_b.e = 1'b0;
    tick();
    b_vin = 1'b0;
    cnt = 1;
    while (!b_vout && cnt < 50) begin
      tick();
      cnt++;
    end
    chk("B latency", cnt, 6);
    tick();
    chk("B queue after 1000/7", qb.size(), 0);
    op_b(16'hFF9C, 16'd7, 1'b1, 16'hFFF2, 16'hFFFE, 1'b0);
    op_b(16'h8000, 16'hFFFF, 1'b1, 16'h8000, 16'h0000, 1'b0);
    op_b(16'd300, 16'd0, 1'b0, 16'hFFFF, 16'd300, 1'b1);

    // 16-bit stream, tags in order under stalls
    n0 = n_acc_b;
    g = 0;
    while (n_acc_b - n0 < 30 && g < 2000) begin
      rand_b();
      b_vin = ($urandom_range(0, 3) != 0);
      b_rdy = 1'($urandom_range(0, 1));
      tick();
      g++;
    end
    b_vin = 1'b0;
    chk("B stream accepted", n_acc_b - n0, 30);
    g = 0;
    while (qb.size() != 0 && g < 2000) begin
      b_rdy = 1'($urandom_range(0, 1));
      tick();
      g++;
    end
    chk("B stream drained", qb.size(), 0);
    b_rdy = 1'b1;
    tick();
    chk("B stream idle", b_busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
